// File: rtl/the_pkg.sv
// Shared operand-B widths, source-select encoding and immediate extension helper.
package the_pkg;
    localparam int N       = 32;
    localparam int ImmBits = 16;

    typedef enum logic [1:0] {
        SRC_REG    = 2'd0,
        SRC_IMM_ZX = 2'd1,
        SRC_IMM_SX = 2'd2,
        SRC_IMM_UP = 2'd3
    } src_sel_t;

    // Shift form of the upper-placement case keeps N == ImmBits legal.
    function automatic logic [N-1:0] extend_imm(src_sel_t sel, logic [ImmBits-1:0] imm);
        logic [N-1:0] r;
        case (sel)
            SRC_IMM_SX: r = N'($signed(imm));
            SRC_IMM_UP: r = N'(imm) << (N - ImmBits);
            default:    r = N'(imm);
        endcase
        return r;
    endfunction
endpackage

// File: rtl/opb_fifo.sv
// Generic WIDTH x DEPTH synchronous FIFO with synchronous flush; data visible one cycle after push.
// Backpressure: wr_ready drops when full (no pass-through on pop); rd_data reads 0 while empty.
module opb_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             wr_valid,
    output logic             wr_ready,
    input  logic [WIDTH-1:0] wr_data,
    output logic             rd_valid,
    input  logic             rd_ready,
    output logic [WIDTH-1:0] rd_data
);
    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL = (PW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [PW:0]      count;
    logic             push;
    logic             pop;

    assign wr_ready = (count != FULL);
    assign rd_valid = (count != '0);
    assign rd_data  = rd_valid ? mem[rd_ptr] : '0;
    assign push     = wr_valid & wr_ready;
    assign pop      = rd_valid & rd_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

    // Storage needs no reset: empty entries are masked by count.
    always_ff @(posedge clk) begin
        if (push && !flush) mem[wr_ptr] <= wr_data;
    end
endmodule

// File: rtl/operand_b_queue.sv
// Operand-B select/extend (optional EX/MEM forwarding under OPB_FWD_EN) feeding a DEPTH-entry queue.
// Latency 1 cycle push->out_valid; in_ready is registered-count based, so execute stalls never reach decode combinationally.
module operand_b_queue #(
    parameter int N        = the_pkg::N,
    parameter int IMM_BITS = the_pkg::ImmBits,
    parameter int DEPTH    = 2,
    parameter int RA_BITS  = 5
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                flush,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [1:0]          src_sel,
    input  logic [IMM_BITS-1:0] imm,
    input  logic [N-1:0]        qs,
    input  logic [RA_BITS-1:0]  rs_addr,
    input  logic                fwd_valid,
    input  logic [RA_BITS-1:0]  fwd_addr,
    input  logic [N-1:0]        fwd_data,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [N-1:0]        operand
);
    import the_pkg::*;

    src_sel_t     sel;
    logic [N-1:0] ext;
    logic [N-1:0] push_data;

    assign sel = src_sel_t'(src_sel);

    always_comb begin
        case (sel)
            SRC_REG:    ext = qs;
            SRC_IMM_ZX: ext = N'(imm);
            SRC_IMM_SX: ext = N'($signed(imm));
            default:    ext = N'(imm) << (N - IMM_BITS);
        endcase
    end

`ifdef OPB_FWD_EN
    // Register 0 is hardwired, so a write to it must never shadow the read.
    logic fwd_hit;
    assign fwd_hit   = (sel == SRC_REG) && fwd_valid && (fwd_addr == rs_addr) && (fwd_addr != '0);
    assign push_data = fwd_hit ? fwd_data : ext;
`else
    logic unused_fwd;
    assign unused_fwd = fwd_valid ^ (^fwd_addr) ^ (^fwd_data) ^ (^rs_addr);
    assign push_data  = ext;
`endif

    opb_fifo #(
        .WIDTH (N),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .flush    (flush),
        .wr_valid (in_valid),
        .wr_ready (in_ready),
        .wr_data  (push_data),
        .rd_valid (out_valid),
        .rd_ready (out_ready),
        .rd_data  (operand)
    );
endmodule
